// File: rtl/f64_convert_i64_pkg.sv
// Shared constants for the integer-to-binary64 converter: binary64 field
// widths, value type tags, and the conversion FSM state encoding.
package f64_convert_i64_pkg;

  localparam int F64_BIAS      = 1023;
  localparam int F64_EXP_W     = 11;
  localparam int F64_FRAC_W    = 52;
  localparam int NORM_STEP_DEF = 8;
  // Shift count width: at most 63 positions of normalisation are needed.
  localparam int SC_W          = 7;

  // Operand-stack value type tags.
  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/f64_round_pack.sv
// Rounds a normalised 64-bit magnitude to 53 significant bits
// (round-to-nearest, ties-to-even) and packs sign/exponent/fraction.
module f64_round_pack
  import f64_convert_i64_pkg::*;
#(
  parameter int BIAS = F64_BIAS
) (
  input  logic            sign_i,
  input  logic [63:0]     mag_i,
  input  logic [SC_W-1:0] sc_i,
  output logic [63:0]     pack_o
);

  logic [F64_EXP_W-1:0]  exp_s;
  logic [F64_EXP_W-1:0]  exp_adj_s;
  logic [F64_FRAC_W:0]   frac_inc_s;
  logic                  lsb_s;
  logic                  guard_s;
  logic                  sticky_s;
  logic                  round_up_s;

  // Rounding increment, carry into the exponent and final field packing.
  always_comb begin
    exp_s      = F64_EXP_W'(BIAS + 63) - {4'd0, sc_i};
    lsb_s      = mag_i[11];
    guard_s    = mag_i[10];
    sticky_s   = |mag_i[9:0];
    round_up_s = guard_s & (lsb_s | sticky_s);
    frac_inc_s = {1'b0, mag_i[62:11]} + {52'd0, round_up_s};
    // A carry out of the fraction means the significand became 2.0:
    // the fraction wraps to zero and the exponent steps up by one.
    if (frac_inc_s[F64_FRAC_W]) begin
      exp_adj_s = exp_s + 11'd1;
    end else begin
      exp_adj_s = exp_s;
    end
    // An unnormalised (zero) magnitude packs as a signed zero.
    if (mag_i[63]) begin
      pack_o = {sign_i, exp_adj_s, frac_inc_s[F64_FRAC_W-1:0]};
    end else begin
      pack_o = {sign_i, 63'd0};
    end
  end

endmodule

// File: rtl/f64_convert_i64.sv
// Multi-cycle f64.convert_i64_s / f64.convert_i64_u functional unit with
// valid/ready handshakes on both sides. Normalises by coarse then single-bit
// left shifts, then rounds and packs in one cycle.
module f64_convert_i64
  import f64_convert_i64_pkg::*;
#(
  parameter int BIAS      = F64_BIAS,
  parameter int NORM_STEP = NORM_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [1:0]  out_type,
  output logic        busy
);

  state_e          state_q, state_d;
  logic [63:0]     mag_q, mag_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            sign_q, sign_d;
  logic [63:0]     out_value_q, out_value_d;

  logic            in_sign_s;
  logic [63:0]     in_mag_s;
  logic [63:0]     pack_s;

  f64_round_pack #(
    .BIAS (BIAS)
  ) u_round_pack (
    .sign_i (sign_q),
    .mag_i  (mag_q),
    .sc_i   (sc_q),
    .pack_o (pack_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mag_q       <= 64'd0;
      sc_q        <= 7'd0;
      sign_q      <= 1'b0;
      out_value_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sc_q        <= sc_d;
      sign_q      <= sign_d;
      out_value_q <= out_value_d;
    end
  end

  // Next-state and datapath update for the IDLE/NORM/ROUND/DONE sequence.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    sc_d        = sc_q;
    sign_d      = sign_q;
    out_value_d = out_value_q;
    in_sign_s   = in_signed & in_value[63];
    // Two's-complement negate; -2^63 naturally maps to magnitude 2^63.
    if (in_sign_s) begin
      in_mag_s = 64'd0 - in_value;
    end else begin
      in_mag_s = in_value;
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign_s;
          mag_d  = in_mag_s;
          sc_d   = 7'd0;
          if (in_mag_s == 64'd0) begin
            out_value_d = 64'd0;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_q[63 -: NORM_STEP] == '0) begin
          mag_d = mag_q << NORM_STEP;
          sc_d  = sc_q + SC_W'(NORM_STEP);
        end else if (!mag_q[63]) begin
          mag_d = mag_q << 1;
          sc_d  = sc_q + 7'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_value_d = pack_s;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs are decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_value = out_value_q;
    if (state_q == ST_DONE) begin
      out_type = TYPE_F64;
    end else begin
      out_type = TYPE_I32;
    end
  end

endmodule
